// File: rtl/iir_biquad_mac_pkg.sv
// Shared widths, selector codes and FSM encoding for the biquad MAC engine.
// Optional feature macro: IIR_ROUND_EN (round half up before the final shift).
package iir_biquad_mac_pkg;

  localparam int unsigned W    = 25;
  localparam int unsigned FRAC = 20;
  localparam int unsigned ACCW = 2 * W + 3;

  // Coefficient selector codes driven to the coefficient mux
  localparam logic [2:0] SEL_A1 = 3'd0;
  localparam logic [2:0] SEL_A2 = 3'd1;
  localparam logic [2:0] SEL_B0 = 3'd2;
  localparam logic [2:0] SEL_B1 = 3'd3;
  localparam logic [2:0] SEL_B2 = 3'd4;

  // Half an output LSB in accumulator scale
  localparam logic [ACCW-1:0] ROUND_BIAS = ACCW'(64'd1 << (FRAC - 1));

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

endpackage

// File: rtl/iir_biquad_mac_sat.sv
// Combinational accumulator-to-sample conversion: optional rounding, arithmetic
// shift by FRAC, then saturation to the signed W-bit range.
// Optional feature macro: IIR_ROUND_EN.
module iir_biquad_mac_sat
  import iir_biquad_mac_pkg::*;
(
  input  logic signed [ACCW-1:0] acc,
  output logic signed [W-1:0]    y_c
);

  localparam logic signed [ACCW-1:0] SAT_MAX = ACCW'(64'd16777215);
  localparam logic signed [ACCW-1:0] SAT_MIN = ~SAT_MAX;

  logic signed [ACCW-1:0] biased;
  logic signed [ACCW-1:0] shifted;

  // Round (optional), shift and clamp
  always_comb begin
`ifdef IIR_ROUND_EN
    biased = acc + $signed(ROUND_BIAS);
`else
    biased = acc;
`endif
    shifted = biased >>> FRAC;
    if (shifted > SAT_MAX) begin
      y_c = {1'b0, {(W-1){1'b1}}};
    end else if (shifted < SAT_MIN) begin
      y_c = {1'b1, {(W-1){1'b0}}};
    end else begin
      y_c = shifted[W-1:0];
    end
  end

endmodule

// File: rtl/iir_biquad_mac.sv
// Sequential direct-form-I biquad: one MAC per clock through an external
// coefficient mux, one result per accepted sample, 7 clocks per sample.
// Optional feature macro: IIR_ROUND_EN (handled in iir_biquad_mac_sat).
module iir_biquad_mac
  import iir_biquad_mac_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  input  logic         sample_valid,
  input  logic [W-1:0] x_in,
  input  logic [W-1:0] coef_in,
  output logic [2:0]   sel_out,
  output logic [W-1:0] y_out,
  output logic         y_valid,
  output logic         busy,
  output logic         overrun
);

  state_t state;
  state_t state_nxt;

  logic accept;
  logic drop;
  logic mac_en;
  logic out_en;

  logic signed [W-1:0]    x0, x1, x2, y1, y2;
  logic signed [W-1:0]    operand;
  logic signed [2*W-1:0]  prod;
  logic signed [ACCW-1:0] acc;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [W-1:0]    y_sat_c;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (sample_valid) state_nxt = ST_MAC;
      ST_MAC:  if (sel_out == SEL_B2) state_nxt = ST_OUT;
      ST_OUT:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath control strobes decoded from the state
  always_comb begin
    accept = 1'b0;
    drop   = 1'b0;
    mac_en = 1'b0;
    out_en = 1'b0;
    case (state)
      ST_IDLE: accept = sample_valid;
      ST_MAC:  begin mac_en = 1'b1; drop = sample_valid; end
      ST_OUT:  begin out_en = 1'b1; drop = sample_valid; end
      default: ;
    endcase
  end

  // Operand paired with the coefficient currently selected
  always_comb begin
    case (sel_out)
      SEL_A1:  operand = y1;
      SEL_A2:  operand = y2;
      SEL_B0:  operand = x0;
      SEL_B1:  operand = x1;
      SEL_B2:  operand = x2;
      default: operand = '0;
    endcase
    prod     = $signed(coef_in) * operand;
    prod_ext = ACCW'(prod);
  end

  iir_biquad_mac_sat u_sat (
    .acc (acc),
    .y_c (y_sat_c)
  );

  // Accumulator, history and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_out <= SEL_A1;
      y_out   <= '0;
      y_valid <= 1'b0;
      busy    <= 1'b0;
      overrun <= 1'b0;
      acc     <= '0;
      x0      <= '0;
      x1      <= '0;
      x2      <= '0;
      y1      <= '0;
      y2      <= '0;
    end else begin
      y_valid <= 1'b0;
      if (drop) overrun <= 1'b1;
      if (accept) begin
        x0      <= $signed(x_in);
        acc     <= '0;
        sel_out <= SEL_A1;
        busy    <= 1'b1;
      end
      if (mac_en) begin
        if (sel_out == SEL_A1 || sel_out == SEL_A2) acc <= acc - prod_ext;
        else                                        acc <= acc + prod_ext;
        if (sel_out != SEL_B2) sel_out <= sel_out + 3'd1;
      end
      if (out_en) begin
        y_out   <= y_sat_c;
        y_valid <= 1'b1;
        x2      <= x1;
        x1      <= x0;
        y2      <= y1;
        y1      <= y_sat_c;
        busy    <= 1'b0;
        sel_out <= SEL_A1;
      end
    end
  end

endmodule
